multi_cycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw and beq.
- Drives the 2-bit instruction-class select into the ALU function selector, plus all datapath enables.
- Handles memory wait states via mem_ready and keeps a retired-instruction counter.

---
 rtl/multi_cycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
//   Moore main-control FSM for a multi-cycle MIPS datapath. It sequences
//   fetch/decode/execute/memory/writeback for R-type, lw, sw and beq, waits on
//   mem_ready during memory accesses, and counts retired instructions.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   opcode            : IR[31:26], valid from DECODE onward
//   zero              : ALU zero flag, qualifies pc_write in BRANCH
//   mem_ready         : current memory access done (FETCH / MEMRD / MEMWR)
//   alu_sel           : 00 CALCU, 01 LOAD(add), 10 SAVE(add), 11 BEQ(sub)
//   pc_write..alu_src_b : datapath steering and enables, decoded from state
//   state             : current state encoding (debug)
//   illegal           : 1-cycle pulse after DECODE sees an unsupported opcode
//   instr_done        : 1-cycle pulse in the FETCH cycle after a retire
//   instr_count       : retired-instruction counter, wraps silently
module multi_cycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         alu_sel,
  output logic               pc_write,
  output logic               pc_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] SEL_CALCU = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SAVE  = 2'b10;
  localparam logic [1:0] SEL_BEQ   = 2'b11;

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic                 instr_done_q, instr_done_d;
  logic [COUNT_W-1:0]   instr_count_q, instr_count_d;
  logic                 retire;

  // Next state, retire detection and the registered pulses.
  always_comb begin
    state_d  = S_FETCH;
    illegal_d = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = S_RWB;
      S_RWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        // Retires whether or not the branch is taken.
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      // Unreachable encodings recover to FETCH.
      default:  state_d = S_FETCH;
    endcase
    instr_done_d  = retire;
    instr_count_d = instr_count_q + COUNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      illegal_q     <= 1'b0;
      instr_done_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_q     <= illegal_d;
      instr_done_q  <= instr_done_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Datapath controls: pure decode of the state register, qualified by
  // mem_ready (FETCH) and zero (BRANCH).
  always_comb begin
    alu_sel    = SEL_CALCU;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_sel   = SEL_LOAD;
        // PC+4 and IR load only once the fetch data is actually there.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b = 2'b11;
        alu_sel   = SEL_LOAD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = (opcode == OP_LW) ? SEL_LOAD : SEL_SAVE;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_sel   = SEL_CALCU;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = SEL_BEQ;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_done  = instr_done_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl. Each instruction is expanded into its sequence
// of expected states (with wait cycles inserted); every cycle the expected
// state, control word and registered pulses/counter are queued and a negedge
// compare process checks the DUT. Literal checks pin the traces and counts.
module tb_multi_cycle_ctrl;
  localparam int CW = 4;
  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MW = 4'd4,
                         MX = 4'd5, EX = 4'd6, RW = 4'd7, BR = 4'd8;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000;

  logic          clk, rst, zero, mem_ready;
  logic [5:0]    opcode;
  logic [1:0]    alu_sel, alu_src_b;
  logic          pc_write, pc_src, iord, mem_read, mem_write, ir_write;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [3:0]    state;
  logic          illegal, instr_done;
  logic [CW-1:0] instr_count;

  multi_cycle_ctrl #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_sel(alu_sel), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .state(state),
    .illegal(illegal), .instr_done(instr_done), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [13:0]   ctrl;
    logic          ill;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] st_log[$];
  int         checks = 0;
  int         errors = 0;

  // Model state: pulses pending for the next cycle and the retired count.
  logic          m_ill, m_done;
  logic [CW-1:0] m_cnt;

  // Control word {alu_sel, pc_write, pc_src, iord, mem_read, mem_write,
  // ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b} for a state.
  function automatic logic [13:0] ctrl_of(input logic [3:0] s, input logic [5:0] op,
                                          input logic z, input logic mr);
    logic [1:0] asel, sb;
    logic pcw, pcs, ad, mrd, mwr, irw, rwr, rd, m2r, sa;
    asel = 2'b00; sb = 2'b00;
    {pcw, pcs, ad, mrd, mwr, irw, rwr, rd, m2r, sa} = '0;
    case (s)
      FE: begin mrd = 1; sb = 2'b01; asel = 2'b01; irw = mr; pcw = mr; end
      DE: begin sb = 2'b11; asel = 2'b01; end
      MA: begin sa = 1; sb = 2'b10; asel = (op == OP_LW) ? 2'b01 : 2'b10; end
      MR: begin ad = 1; mrd = 1; end
      MW: begin rwr = 1; m2r = 1; end
      MX: begin ad = 1; mwr = 1; end
      EX: begin sa = 1; asel = 2'b00; end
      RW: begin rwr = 1; rd = 1; end
      BR: begin sa = 1; asel = 2'b11; pcs = 1; pcw = z; end
      default: ;
    endcase
    return {asel, pcw, pcs, ad, mrd, mwr, irw, rwr, rd, m2r, sa, sb};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One cycle in expected state s; ret marks a retiring state, ill an
  // illegal decode.
  task automatic cyc(input logic [3:0] s, input logic mr, input logic ret, input logic ill);
    exp_t e;
    mem_ready = mr;
    e.st   = s;
    e.ctrl = ctrl_of(s, opcode, zero, mr);
    e.ill  = m_ill;
    e.done = m_done;
    e.cnt  = m_cnt;
    expq.push_back(e);
    m_ill  = ill;
    m_done = ret;
    if (ret) m_cnt = m_cnt + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    logic bad;
    bad = !(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ);
    opcode = op;
    zero   = z;
    repeat (fw) cyc(FE, 1'b0, 1'b0, 1'b0);
    cyc(FE, 1'b1, 1'b0, 1'b0);
    cyc(DE, 1'b1, 1'b0, bad);
    if (op == OP_R) begin
      cyc(EX, 1'b1, 1'b0, 1'b0);
      cyc(RW, 1'b1, 1'b1, 1'b0);
    end else if (op == OP_LW) begin
      cyc(MA, 1'b1, 1'b0, 1'b0);
      repeat (mw) cyc(MR, 1'b0, 1'b0, 1'b0);
      cyc(MR, 1'b1, 1'b0, 1'b0);
      cyc(MW, 1'b1, 1'b1, 1'b0);
    end else if (op == OP_SW) begin
      cyc(MA, 1'b1, 1'b0, 1'b0);
      repeat (mw) cyc(MX, 1'b0, 1'b0, 1'b0);
      cyc(MX, 1'b1, 1'b1, 1'b0);
    end else if (op == OP_BEQ) begin
      cyc(BR, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    m_ill = 1'b0; m_done = 1'b0; m_cnt = '0;
  endtask

  task automatic chk_trace(input string name, input int base, input int n, input int tr[8]);
    for (int i = 0; i < n; i++) begin
      if (base + i < st_log.size()) chk(name, int'(st_log[base + i]), tr[i]);
      else chk(name, -1, tr[i]);
    end
  endtask

  // Compare process: checks the DUT against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        st_log.push_back(state);
        chk("state", int'(state), int'(e.st));
        chk("ctrl", int'({alu_sel, pc_write, pc_src, iord, mem_read, mem_write, ir_write,
                          reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b}), int'(e.ctrl));
        chk("illegal", int'(illegal), int'(e.ill));
        chk("instr_done", int'(instr_done), int'(e.done));
        chk("instr_count", int'(instr_count), int'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int tr[8];
    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
    m_ill = 1'b0; m_done = 1'b0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(instr_count), 0);
    chk("rst_mem_read", int'(mem_read), 1);
    chk("rst_pc_write", int'(pc_write), 1);

    // R-type
    base = st_log.size();
    run_instr(OP_R, 1'b0, 0, 0);
    tr = '{0, 1, 6, 7, 0, 0, 0, 0};
    chk_trace("r_trace", base, 4, tr);
    chk("r_state_after", int'(state), 0);
    chk("r_done", int'(instr_done), 1);
    chk("r_count", int'(instr_count), 1);

    // lw with 2 fetch waits and 1 memory wait
    base = st_log.size();
    run_instr(OP_LW, 1'b0, 2, 1);
    tr = '{0, 0, 0, 1, 2, 3, 3, 4};
    chk_trace("lw_trace", base, 8, tr);
    chk("lw_count", int'(instr_count), 2);

    // sw
    base = st_log.size();
    run_instr(OP_SW, 1'b0, 0, 0);
    tr = '{0, 1, 2, 5, 0, 0, 0, 0};
    chk_trace("sw_trace", base, 4, tr);
    chk("sw_count", int'(instr_count), 3);

    // beq taken, then not taken
    base = st_log.size();
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    tr = '{0, 1, 8, 0, 1, 8, 0, 0};
    chk_trace("beq_trace", base, 6, tr);
    chk("beq_count", int'(instr_count), 5);

    // illegal opcode
    run_instr(OP_ADDI, 1'b0, 0, 0);
    chk("ill_state", int'(state), 0);
    chk("ill_pulse", int'(illegal), 1);
    chk("ill_count", int'(instr_count), 5);
    cyc(FE, 1'b0, 1'b0, 1'b0);
    chk("ill_cleared", int'(illegal), 0);
    run_instr(OP_SW, 1'b0, 0, 2);
    chk("sw_wait_count", int'(instr_count), 6);

    // reset in MEMRD while waiting on memory
    opcode = OP_LW;
    cyc(FE, 1'b1, 1'b0, 1'b0);
    cyc(DE, 1'b1, 1'b0, 1'b0);
    cyc(MA, 1'b1, 1'b0, 1'b0);
    cyc(MR, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    do_reset();
    chk("midrst_state", int'(state), 0);
    chk("midrst_count", int'(instr_count), 0);
    chk("midrst_done", int'(instr_done), 0);

    // counter wrap with COUNT_W=4
    repeat (15) run_instr(OP_BEQ, 1'b0, 0, 0);
    chk("wrap_pre", int'(instr_count), 15);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    chk("wrap_zero", int'(instr_count), 0);
    chk("wrap_done", int'(instr_done), 1);
    cyc(FE, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
